// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state type, counter sizing
// helper and the widest operand the serial units are built for.
package arith_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Width of a counter that indexes bits 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done bus of the serial subtractor.
//
// Handshake: the master raises start with a and b valid; the slave accepts
// it on the first rising edge where ready=1 and start=1 (a and b are captured
// on that edge, start is ignored while ready=0). done is a one-cycle pulse
// marking the cycle in which diff/borrow/overflow first carry the new
// result; those outputs then hold until the next done or reset.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  ready, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output ready, done, diff, borrow, overflow
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bin, producing difference and borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Borrow out when y exceeds x, or when they are equal and a borrow ripples in.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first through a
// single registered borrow. Legal WIDTH range is 2..MAX_WIDTH.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus,
    output sub_state_e           dbg_state_o
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, sd_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] sd_next;
    logic             ready_d;
    logic             done_d;

    // The single bit cell shared by every bit position over time.
    full_subtractor u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign sd_next = {bit_d, sd_q[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q       <= '0;
            sb_q       <= '0;
            sd_q       <= '0;
            cnt_q      <= '0;
            br_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                sa_q    <= bus.a;
                sb_q    <= bus.b;
                sd_q    <= '0;
                cnt_q   <= '0;
                br_q    <= 1'b0;
                a_msb_q <= bus.a[WIDTH-1];
                b_msb_q <= bus.b[WIDTH-1];
            end else if (state_q == RUN) begin
                sa_q  <= sa_q >> 1;
                sb_q  <= sb_q >> 1;
                sd_q  <= sd_next;
                br_q  <= bit_bout;
                cnt_q <= cnt_q + CW'(1);
                // Last bit: register the complete result as DONE is entered.
                if (cnt_q == LAST_CNT) begin
                    diff_q     <= sd_next;
                    borrow_q   <= bit_bout;
                    overflow_q <= (a_msb_q != b_msb_q) && (sd_next[WIDTH-1] != a_msb_q);
                end
            end
        end
    end

    assign bus.ready    = ready_d;
    assign bus.done     = done_d;
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed cases, mid-run
// interference, asynchronous reset mid-operation and a randomised sweep
// with start held high, all compared against an arithmetic reference model.
module tb_serial_subtractor;
    import arith_pkg::*;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    sub_state_e dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W+1:0] exp_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500us;
        $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference: packs {overflow, borrow, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi, as_s, bs_s, res;
        logic [W-1:0] d;
        logic br, ov;
        ai   = int'(a);
        bi   = int'(b);
        d    = W'(ai - bi + (1 << W));
        br   = (ai < bi);
        as_s = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
        bs_s = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
        res  = as_s - bs_s;
        ov   = (res > (1 << (W - 1)) - 1) || (res < -(1 << (W - 1)));
        return {ov, br, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // After an accepted start edge: expect done exactly W edges later with the
    // queued result, and ready back the cycle after. Optionally interfere at
    // RUN cycle 3 with a start pulse and new operands.
    task automatic run_and_check(input bit inject, input bit keep_start);
        logic [W+1:0] e;
        for (int i = 1; i <= W + 1; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("ready_low_in_run", 32'(bus.ready), 32'd0);
            if (i == W) begin
                check("done_pulse", 32'(bus.done), 32'd1);
                if (exp_q.size() == 0) begin
                    check("exp_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("diff", 32'(bus.diff), 32'(e[W-1:0]));
                    check("borrow", 32'(bus.borrow), 32'(e[W]));
                    check("overflow", 32'(bus.overflow), 32'(e[W+1]));
                end
            end else begin
                check("done_quiet", 32'(bus.done), 32'd0);
            end
            if (i == W + 1) check("ready_back", 32'(bus.ready), 32'd1);
            if (inject && i == 3) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
            end
            if (inject && i == 4) begin
                @(negedge clk);
                bus.start = keep_start;
            end
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        run_and_check(inject, 1'b0);
    endtask

    // Directed and randomised sequence.
    initial begin
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow", 32'(bus.borrow), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'd9, 8'd3, 1'b0);
        do_op(8'd3, 8'd9, 1'b0);
        do_op(8'h80, 8'h01, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0);
        do_op(8'h5A, 8'h5A, 1'b0);
        do_op(8'h00, 8'h01, 1'b0);
        do_op(8'hC3, 8'h21, 1'b1);

        // Asynchronous reset part-way through RUN.
        do_op(8'h7F, 8'hFF, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h12;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_diff", 32'(bus.diff), 32'd0);
        check("arst_borrow", 32'(bus.borrow), 32'd0);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        check("arst_ready", 32'(bus.ready), 32'd1);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("arst_no_done", 32'(bus.done), 32'd0);
        end
        do_op(8'h55, 8'h12, 1'b0);

        // Randomised sweep with start held high; back-to-back every W+2 cycles.
        check("sweep_entry_ready", 32'(bus.ready), 32'd1);
        for (int j = 0; j < 500; j++) begin
            @(negedge clk);
            ra        = W'($urandom_range(0, 255));
            rb        = W'($urandom_range(0, 255));
            bus.start = 1'b1;
            bus.a     = ra;
            bus.b     = rb;
            exp_q.push_back(model(ra, rb));
            @(posedge clk);
            #1;
            @(negedge clk);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            run_and_check(1'b0, 1'b1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
